// File: rtl/audio_sample_sequencer.sv
// audio_sample_sequencer: walks a sample ROM address window at a programmable
// rate. Each ROM word is registered into sample_out and announced with a
// one-cycle sample_valid strobe. Playback can be one-shot or looping, and it
// supports pause, stop and restart.
module audio_sample_sequencer #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_pause,
  input  logic                  i_loop_en,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH-1:0] i_end_addr,
  input  logic [DIV_WIDTH-1:0]  i_rate_div,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic [DATA_WIDTH-1:0] o_sample_out,
  output logic                  o_sample_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;

  state_t                r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [ADDR_WIDTH-1:0] r_start_lat;
  logic [ADDR_WIDTH-1:0] r_end_lat;
  logic [DIV_WIDTH-1:0]  r_rate_lat;
  logic [DIV_WIDTH-1:0]  r_div_cnt;
  logic [DATA_WIDTH-1:0] r_sample_out;
  logic                  r_sample_valid;
  logic                  r_done;
  logic                  w_tick;
  logic                  w_last;

  // A tick fires when the divider has run out while playing unpaused.
  assign w_tick = (r_state == S_PLAY) && !i_pause && (r_div_cnt == '0);
  assign w_last = (r_rom_addr == r_end_lat);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state: stop beats start, and start beats the end-of-run tick.
  always_comb begin
    w_next_state = r_state;
    if (i_stop)                            w_next_state = S_IDLE;
    else if (i_start)                      w_next_state = S_PLAY;
    else if (w_tick && w_last && !i_loop_en) w_next_state = S_IDLE;
  end

  // State-decoded outputs.
  always_comb begin
    o_busy = (r_state == S_PLAY);
  end

  // Datapath: config latch, divider, address walk and sample capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rom_addr     <= '0;
      r_start_lat    <= '0;
      r_end_lat      <= '0;
      r_rate_lat     <= '0;
      r_div_cnt      <= '0;
      r_sample_out   <= '0;
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
      if (i_stop) begin
        // Abort: address and last sample simply hold.
      end else if (i_start) begin
        // A restart discards any tick that was due in this cycle.
        r_rom_addr  <= i_start_addr;
        r_div_cnt   <= '0;
        r_start_lat <= i_start_addr;
        r_end_lat   <= i_end_addr;
        r_rate_lat  <= i_rate_div;
      end else if (w_tick) begin
        r_sample_out   <= i_rom_data;
        r_sample_valid <= 1'b1;
        r_div_cnt      <= r_rate_lat;
        if (!w_last)        r_rom_addr <= r_rom_addr + ADDR_WIDTH'(1);
        else if (i_loop_en) r_rom_addr <= r_start_lat;
        else                r_done     <= 1'b1;
      end else if ((r_state == S_PLAY) && !i_pause) begin
        r_div_cnt <= r_div_cnt - DIV_WIDTH'(1);
      end
    end
  end

  assign o_rom_addr     = r_rom_addr;
  assign o_sample_out   = r_sample_out;
  assign o_sample_valid = r_sample_valid;
  assign o_done         = r_done;

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Bench for audio_sample_sequencer: the ROM is modelled as
// ROM[a] = a ^ 16'hA5A5. Expected samples are queued when a run is started,
// and they are popped by a monitor on every sample_valid.
module tb_audio_sample_sequencer;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          rst, start, stop, pause, loop_en;
  logic [AW-1:0] start_addr, end_addr, rom_addr;
  logic [VW-1:0] rate_div;
  logic [DW-1:0] rom_data, sample_out;
  logic          sample_valid, busy, done;

  audio_sample_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_pause(pause),
    .i_loop_en(loop_en), .i_start_addr(start_addr), .i_end_addr(end_addr),
    .i_rate_div(rate_div), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_sample_out(sample_out), .o_sample_valid(sample_valid), .o_busy(busy),
    .o_done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {2'b00, a} ^ 16'hA5A5;
  endfunction

  assign rom_data = rom_word(rom_addr);

  typedef struct {
    logic [DW-1:0] data;
    logic          done;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [AW-1:0] sa;
    logic [AW-1:0] ea;
    logic [VW-1:0] rd;
    logic          lp;
    int            n;
  } vec_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every valid must match the head of the queue.
  always @(negedge clk) begin
    if (sample_valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sample_data", int'(sample_out), int'(e.data));
        check("sample_done", int'(done), int'(e.done));
        check("sample_cycle", cyc, e.cyc);
      end
    end else if (done) begin
      check("done_without_valid", 1, 0);
    end
  end

  // Queue the expected samples of a run and pulse start with its configuration.
  task automatic start_run(input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                           input logic [VW-1:0] rd, input logic lp, input int n);
    logic [AW-1:0] a;
    a = sa;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.data = rom_word(a);
      e.done = !lp && (a == ea);
      e.cyc  = cyc + 2 + i * (int'(rd) + 1);
      q.push_back(e);
      if (a == ea) begin
        if (!lp) break;
        a = sa;
      end else begin
        a = a + AW'(1);
      end
    end
    start_addr = sa; end_addr = ea; rate_div = rd; loop_en = lp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait until every queued sample has been seen, within a bounded budget.
  task automatic drain(input int budget);
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{sa: 14'h0010, ea: 14'h0013, rd: 16'd3, lp: 1'b0, n: 4};
    vecs[1] = '{sa: 14'h3FFE, ea: 14'h0001, rd: 16'd0, lp: 1'b1, n: 9};
    vecs[2] = '{sa: 14'h0005, ea: 14'h0005, rd: 16'd2, lp: 1'b0, n: 1};
    vecs[3] = '{sa: 14'h0005, ea: 14'h0005, rd: 16'd1, lp: 1'b1, n: 3};
    vecs[4] = '{sa: 14'h3FFF, ea: 14'h0000, rd: 16'd1, lp: 1'b0, n: 2};

    rst = 1'b1; start = 0; stop = 0; pause = 0; loop_en = 0;
    start_addr = '0; end_addr = '0; rate_div = '0;
    repeat (3) @(negedge clk);
    check("rst_addr", int'(rom_addr), 0);
    check("rst_sample", int'(sample_out), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven runs.
    for (int v = 0; v < 5; v++) begin
      start_run(vecs[v].sa, vecs[v].ea, vecs[v].rd, vecs[v].lp, vecs[v].n);
      check("busy_playing", int'(busy), 1);
      drain(200);
      if (vecs[v].lp) begin
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
      end
      check("busy_after_run", int'(busy), 0);
      repeat (4) @(negedge clk);
    end

    // Pause: 10 clocks starting one clock after a valid.
    begin
      int p;
      start_run(14'h0200, 14'h02FF, 16'd3, 1'b0, 1);
      drain(50);
      p = cyc;
      @(negedge clk);
      pause = 1'b1;
      q.push_back('{data: rom_word(14'h0201), done: 1'b0, cyc: p + 14});
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (i == 2 || i == 9) check("pause_addr_frozen", int'(rom_addr), 'h0201);
      end
      pause = 1'b0;
      drain(50);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end

    // Mid-play stop: sample holds and no further valids appear.
    start_run(14'h0300, 14'h03FF, 16'd2, 1'b0, 2);
    drain(50);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    repeat (8) @(negedge clk);
    check("stop_sample_hold", int'(sample_out), int'(rom_word(14'h0301)));
    check("stop_addr_hold", int'(rom_addr), 'h0302);

    // Start and stop together while idle: stays idle.
    start_addr = 14'h0400; end_addr = 14'h0410; rate_div = 0; loop_en = 0;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle_busy", int'(busy), 0);
    repeat (5) @(negedge clk);

    // Reset mid-play, then a clean replay.
    start_run(14'h0040, 14'h004F, 16'd1, 1'b0, 2);
    drain(50);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_addr", int'(rom_addr), 0);
    check("midrst_sample", int'(sample_out), 0);
    check("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    start_run(14'h0040, 14'h0042, 16'd0, 1'b0, 3);
    drain(50);
    check("replay_busy", int'(busy), 0);

    // Restart while playing: the new window starts two clocks later.
    start_run(14'h0020, 14'h0030, 16'd7, 1'b0, 1);
    drain(50);
    repeat (2) @(negedge clk);
    start_run(14'h0100, 14'h0102, 16'd0, 1'b0, 3);
    drain(50);
    check("restart_busy", int'(busy), 0);

    repeat (10) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
